// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state codes and the
// bit-timing helper used by both the transmitter divider and the receiver.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 3;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  // Even number of clk cycles per sample so the half-period load is exact.
  function automatic int uart_tick_cycles(input int clk_hz, input int baud);
    return ((clk_hz / (baud * OVERSAMPLE)) / 2) * 2;
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running sample tick generator; a load re-phases it to half a sample
// period so the following ticks fall in the middle of each sample slot.
module uart_rx_tick_gen #(
  parameter int TICK_CYCLES = 34
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TICK_CYCLES / 2 - 1);
    end else if (cnt == '0) begin
      cnt <= CW'(TICK_CYCLES - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !load;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3x oversampling, majority vote per bit and a
// one-entry holding register with framing-error and overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 1_000_000,
  parameter int BAUD_RATE       = 9600
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 RxWire,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxAck,
  output logic                 RxFrameError,
  output logic                 RxOverrun,
  output logic                 RxBusy,
  output logic [2:0]           RxState
);

  localparam int TICK_CYCLES = uart_tick_cycles(CLOCK_FREQUENCY, BAUD_RATE);

  logic                 sync1, rx_s;
  rx_state_t            state, state_next;
  logic [1:0]           phase;
  logic [1:0]           samples;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 deliver;
  logic                 tick, start_load, sample_tick, bit_done, maj;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RxWire;
      rx_s  <= sync1;
    end
  end

  assign start_load  = (state == RX_IDLE) && !rx_s;
  assign sample_tick = tick && (state != RX_IDLE);
  assign bit_done    = sample_tick && (phase == 2'(OVERSAMPLE - 1));
  assign maj         = (samples[0] & samples[1]) | (samples[0] & rx_s) |
                       (samples[1] & rx_s);

  uart_rx_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (start_load),
    .tick  (tick)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:      if (!rx_s) state_next = RX_START;
      RX_START:     if (bit_done) state_next = maj ? RX_IDLE : RX_DATA;
      RX_DATA:      if (bit_done && bit_cnt == 3'd7) state_next = RX_STOP;
      RX_STOP:      if (bit_done) state_next = maj ? RX_IDLE : RX_WAIT_IDLE;
      RX_WAIT_IDLE: if (rx_s) state_next = RX_IDLE;
      default:      state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      phase        <= '0;
      samples      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      deliver      <= 1'b0;
      RxFrameError <= 1'b0;
    end else begin
      if (start_load) begin
        phase <= '0;
      end else if (sample_tick) begin
        phase <= (phase == 2'(OVERSAMPLE - 1)) ? 2'd0 : phase + 2'd1;
      end
      if (sample_tick && phase == 2'd0) samples[0] <= rx_s;
      if (sample_tick && phase == 2'd1) samples[1] <= rx_s;
      if (state == RX_START && bit_done) begin
        bit_cnt <= '0;
      end else if (state == RX_DATA && bit_done) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {maj, shift[DATA_BITS-1:1]};
      end
      deliver      <= (state == RX_STOP) && bit_done && maj;
      RxFrameError <= (state == RX_STOP) && bit_done && !maj;
    end
  end

  // Holding register: RxValid is a level that stays high until RxAck is seen.
  // A byte arriving while RxValid is high is kept only if RxAck is high in that
  // same cycle; otherwise it is dropped and RxOverrun pulses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RxData    <= '0;
      RxValid   <= 1'b0;
      RxOverrun <= 1'b0;
    end else begin
      RxOverrun <= 1'b0;
      if (deliver) begin
        if (!RxValid || RxAck) begin
          RxData  <= shift;
          RxValid <= 1'b1;
        end else begin
          RxOverrun <= 1'b1;
        end
      end else if (RxAck) begin
        RxValid <= 1'b0;
      end
    end
  end

  assign RxBusy  = (state != RX_IDLE);
  assign RxState = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 MHz / 9600 baud (102-cycle bits).
module tb_uart_rx;

  localparam int BIT = 102;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       RxWire;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxAck;
  logic       RxFrameError;
  logic       RxOverrun;
  logic       RxBusy;
  logic [2:0] RxState;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    logic       ack_first;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t tbl[7];

  uart_rx #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(9600)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .RxWire       (RxWire),
    .RxData       (RxData),
    .RxValid      (RxValid),
    .RxAck        (RxAck),
    .RxFrameError (RxFrameError),
    .RxOverrun    (RxOverrun),
    .RxBusy       (RxBusy),
    .RxState      (RxState)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (RxFrameError) fe_cnt++;
    if (RxOverrun) ov_cnt++;
    if (RxBusy) busy_cnt++;
    if (RxValid && (!valid_prev || RxData != data_prev)) got_q.push_back(RxData);
    valid_prev = RxValid;
    data_prev  = RxData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold);
    @(negedge Clk);
    RxWire = 1'b0;
    repeat (BIT) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      RxWire = d[i];
      repeat (BIT) @(negedge Clk);
    end
    RxWire = stop;
    repeat (BIT + hold) @(negedge Clk);
    RxWire = 1'b1;
  endtask

  task automatic ack_pulse();
    @(negedge Clk);
    RxAck = 1'b1;
    @(negedge Clk);
    RxAck = 1'b0;
  endtask

  initial begin
    int fe_base, ov_base, busy_base, got_base;

    tbl[0] = '{8'hA5, 1'b1, 0,   1'b1, 1'b1, 8'hA5, 0, 0};
    tbl[1] = '{8'h00, 1'b1, 0,   1'b1, 1'b1, 8'h00, 0, 0};
    tbl[2] = '{8'hFF, 1'b1, 0,   1'b1, 1'b1, 8'hFF, 0, 0};
    tbl[3] = '{8'h3C, 1'b0, 300, 1'b1, 1'b0, 8'hFF, 1, 0};
    tbl[4] = '{8'h81, 1'b1, 0,   1'b0, 1'b1, 8'h81, 0, 0};
    tbl[5] = '{8'h11, 1'b1, 0,   1'b1, 1'b1, 8'h11, 0, 0};
    tbl[6] = '{8'h22, 1'b1, 0,   1'b0, 1'b1, 8'h11, 0, 1};

    Reset  = 1'b0;
    RxWire = 1'b1;
    RxAck  = 1'b0;
    repeat (5) @(negedge Clk);
    check("reset_data", RxData, 8'h00);
    check("reset_valid", RxValid, 0);
    check("reset_fe", RxFrameError, 0);
    check("reset_ov", RxOverrun, 0);
    check("reset_busy", RxBusy, 0);
    check("reset_state", RxState, 0);
    Reset = 1'b1;
    repeat (10) @(negedge Clk);

    // First frame: exact delivery latency after the 3rd stop sample.
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        @(negedge Clk);
        repeat (1006) @(negedge Clk);
        check("t1_valid_before", RxValid, 0);
        repeat (2) @(negedge Clk);
        check("t1_valid_after", RxValid, 1);
        check("t1_data", RxData, 8'hA5);
      end
    join
    repeat (20) @(negedge Clk);
    check("t1_busy_idle", RxBusy, 0);
    check("t1_fe", fe_cnt, 0);

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].ack_first) ack_pulse();
      fe_base = fe_cnt;
      ov_base = ov_cnt;
      send_frame(tbl[v].data, tbl[v].stop, tbl[v].hold);
      repeat (20) @(negedge Clk);
      check($sformatf("vec%0d_valid", v), RxValid, tbl[v].exp_valid);
      check($sformatf("vec%0d_data", v), RxData, tbl[v].exp_data);
      check($sformatf("vec%0d_fe", v), fe_cnt - fe_base, tbl[v].exp_fe);
      check($sformatf("vec%0d_ov", v), ov_cnt - ov_base, tbl[v].exp_ov);
      check($sformatf("vec%0d_busy", v), RxBusy, 0);
      check($sformatf("vec%0d_state", v), RxState, 0);
    end

    // Short low glitch on an idle line is rejected as a false start.
    ack_pulse();
    fe_base   = fe_cnt;
    busy_base = busy_cnt;
    @(negedge Clk);
    RxWire = 1'b0;
    repeat (20) @(negedge Clk);
    RxWire = 1'b1;
    repeat (150) @(negedge Clk);
    check("glitch_busy_seen", (busy_cnt - busy_base) > 0, 1);
    check("glitch_state", RxState, 0);
    check("glitch_valid", RxValid, 0);
    check("glitch_fe", fe_cnt - fe_base, 0);

    // Second byte accepted because RxAck lands on its delivery cycle.
    send_frame(8'h11, 1'b1, 0);
    repeat (20) @(negedge Clk);
    ov_base = ov_cnt;
    fork
      send_frame(8'h22, 1'b1, 0);
      begin
        @(negedge Clk);
        repeat (1006) @(negedge Clk);
        check("ackdlv_valid_pre", RxValid, 1);
        RxAck = 1'b1;
        @(negedge Clk);
        RxAck = 1'b0;
        check("ackdlv_valid_hold", RxValid, 1);
        check("ackdlv_data", RxData, 8'h22);
      end
    join
    repeat (20) @(negedge Clk);
    check("ackdlv_valid_end", RxValid, 1);
    check("ackdlv_ov", ov_cnt - ov_base, 0);

    // Reset in the middle of the data bits.
    fork
      send_frame(8'h5A, 1'b1, 0);
      begin
        @(negedge Clk);
        repeat (BIT * 5 + 20) @(negedge Clk);
        check("mid_busy_pre", RxBusy, 1);
        Reset = 1'b0;
        #1;
        check("mid_rst_data", RxData, 8'h00);
        check("mid_rst_valid", RxValid, 0);
        check("mid_rst_busy", RxBusy, 0);
        check("mid_rst_state", RxState, 0);
        check("mid_rst_fe", RxFrameError, 0);
        check("mid_rst_ov", RxOverrun, 0);
      end
    join
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    repeat (10) @(negedge Clk);
    fe_base = fe_cnt;
    send_frame(8'hC3, 1'b1, 0);
    repeat (20) @(negedge Clk);
    check("post_rst_valid", RxValid, 1);
    check("post_rst_data", RxData, 8'hC3);
    check("post_rst_fe", fe_cnt - fe_base, 0);

    // Continuous transmitter stream, every byte acknowledged.
    ack_pulse();
    repeat (5) @(negedge Clk);
    fe_base  = fe_cnt;
    ov_base  = ov_cnt;
    got_base = got_q.size();
    exp_q = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    fork
      begin
        for (int k = 0; k < 4; k++) send_frame(exp_q[k], 1'b1, 0);
      end
      begin
        for (int c = 0; c < 4 * (10 * BIT + 2) + 200; c++) begin
          @(negedge Clk);
          RxAck = RxValid && !RxAck;
        end
        RxAck = 1'b0;
      end
    join
    check("loop_count", got_q.size() - got_base, 4);
    for (int k = 0; k < 4; k++) begin
      if (got_base + k < got_q.size())
        check($sformatf("loop_byte%0d", k), got_q[got_base + k], exp_q[k]);
      else
        check($sformatf("loop_byte%0d_missing", k), 0, 1);
    end
    check("loop_fe", fe_cnt - fe_base, 0);
    check("loop_ov", ov_cnt - ov_base, 0);
    check("loop_state", RxState, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, 8N1, LSB first, idle-high line. Pairs with the existing UART transmitter.
- Oversamples each bit 3x and takes a majority vote per bit.
- Holds the received byte in a one-entry holding register with a valid/ack handshake.
- Flags framing errors and overruns.
- Bit timing uses the same integer rounding as the transmitter, so TX and RX baud match exactly.

Parameters:
- CLOCK_FREQUENCY, 1_000_000: Clk frequency in Hz.
- BAUD_RATE, 9600: line baud rate.
- TICK_CYCLES (derived localparam): ((CLOCK_FREQUENCY/(BAUD_RATE*3))/2)*2. Sample period in Clk cycles. One bit = 3*TICK_CYCLES.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- RxWire  in  1  serial line, asynchronous to Clk.
- RxData  out  8  last accepted byte.
- RxValid  out  1  level; high while RxData holds an unacknowledged byte.
- RxAck  in  1  consumer acknowledge; clears RxValid.
- RxFrameError  out  1  one-cycle pulse on a bad stop bit.
- RxOverrun  out  1  one-cycle pulse when a byte is dropped.
- RxBusy  out  1  high when state != IDLE.

Behaviour:
- Reset values (async, while Reset=0):
  - RxData=8'h00; RxValid, RxFrameError, RxOverrun, RxBusy = 0.
  - Synchronizer flops = 1. State = IDLE, bit counter = 0, tick counter = 0.
  - Reset mid-frame abandons the frame with no output.
- Input sync: 2-flop synchronizer on RxWire; all logic uses the synchronized value rx_s (2-cycle latency).
- Tick generator:
  - Counts down from TICK_CYCLES-1 and pulses tick on reaching 0, then reloads.
  - On start detection it loads TICK_CYCLES/2-1, so samples land at 0.5T, 1.5T and 2.5T into each bit (T = TICK_CYCLES).
  - Free-running otherwise; ticks are ignored in IDLE.
- Per bit: 3 ticks, samples s0..s2. Bit value = majority(s0,s1,s2), evaluated on the 3rd tick.
- IDLE: rx_s=0 (falling edge relative to idle-high) -> load tick generator, go to START.
- START:
  - On the 3rd tick: majority 0 -> DATA with bit counter = 0.
  - Majority 1 -> false start; go to IDLE, no output.
- DATA:
  - On each 3rd tick: shift register <= {bit, shift[7:1]} and increment the bit counter.
  - After bit 7 -> STOP.
- STOP, on the 3rd tick:
  - Majority 1 -> deliver byte (see handshake), go to IDLE immediately (at 2.5T into the stop bit), so back-to-back frames are caught.
  - Majority 0 -> pulse RxFrameError for 1 cycle, drop the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then IDLE. A break condition produces only one error pulse.
- Delivery handshake (on the cycle after the 3rd stop tick):
  - RxValid=0 -> RxData <= byte, RxValid <= 1.
  - RxValid=1 and RxAck=1 in the same cycle -> RxData <= new byte, RxValid stays 1.
  - RxValid=1 and RxAck=0 -> new byte dropped, RxData unchanged, RxOverrun pulses 1 cycle.
- RxAck while RxValid=0: no effect. RxAck with no delivery that cycle: RxValid <= 0.
- State encoding: 3-bit; IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4. Other codes recover to IDLE.
- Widths:
  - Tick counter: clog2(TICK_CYCLES) bits.
  - Sample phase counter: 2 bits, wraps 2->0.
  - Bit counter: 3 bits; wrap 7->0 is the DATA exit condition.

Decomposition:
- Shared package uart_pkg:
  - Rx state localparams.
  - Function uart_tick_cycles(clk, baud), also used by the transmitter's divider setting.
  - Constants DATA_BITS=8, OVERSAMPLE=3.
- One sub-module, uart_rx_tick_gen: down-counter with synchronous load of half period, tick output, async active-low reset.

Test Plan:
All tests use CLOCK_FREQUENCY=1_000_000 and BAUD_RATE=9600, giving TICK_CYCLES=34 and a bit period of 102 cycles.
1. Send 0xA5 with 102-cycle bits -> RxValid rises within 2+1 cycles of the 3rd stop sample; RxData=0xA5; RxFrameError=0; RxBusy low afterwards.
2. Low glitch of 20 cycles on an idle line -> RxBusy pulses, START rejects, no RxValid, no RxFrameError; state back to IDLE.
3. Send 0x3C with stop bit 0, hold the line low 300 cycles, release, then send 0x81 -> exactly one RxFrameError pulse; then RxValid with RxData=0x81.
4. Send 0x11 then 0x22 back-to-back without RxAck -> RxData=0x11 and one RxOverrun pulse. Repeat with RxAck asserted on the delivery cycle of the 2nd byte -> RxData=0x22, RxValid stays 1, no RxOverrun.
5. Assert Reset low mid-DATA of 0x5A (after bit 3) -> all outputs 0 immediately. After release, a clean 0xC3 is received correctly.
6. Loopback from the existing UART transmitter (same parameters) sending 0x00, 0xFF, 0x55, 0xAA continuously with RxAck on every RxValid -> all 4 bytes received in order, zero errors or overruns.
